// File: rtl/seq_detect_moore_param.sv
// rtl/seq_detect_moore_param.sv - run-time loadable Moore serial-pattern detector with saturating match counter
module seq_detect_moore_param #(
    parameter int                 PAT_MAX     = 8,
    parameter int                 LEN_W       = $clog2(PAT_MAX + 1),
    parameter logic [PAT_MAX-1:0] DEFAULT_PAT = PAT_MAX'(8'b0000_0101),
    parameter int                 DEFAULT_LEN = 3,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_MAX-1:0] pat_in,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               cnt_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   state_k
);

    logic [PAT_MAX-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   k;
    logic [LEN_W-1:0]   k_next;
    logic [LEN_W-1:0]   len_clamped;
    logic [PAT_MAX-1:0] p_seq;
    logic               hit;

    int m;
    int best;
    logic ok;

    function automatic logic bit_at(input logic [PAT_MAX-1:0] v, input int idx);
        logic [PAT_MAX-1:0] s;
        s = v >> idx;
        return s[0];
    endfunction

    always_comb begin
        len_clamped = pat_len;
        if (pat_len == '0)
            len_clamped = LEN_W'(1);
        else if (pat_len > LEN_W'(PAT_MAX))
            len_clamped = LEN_W'(PAT_MAX);
    end

    // Pattern re-ordered so p_seq[0] is the first bit expected on the line
    always_comb begin
        p_seq = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(len))
                p_seq[i] = bit_at(pattern, int'(len) - 1 - i);
        end
    end

    // S = first m pattern bits followed by in; find longest suffix of S that is a pattern prefix
    always_comb begin
        m    = (k == len && !overlap) ? 0 : int'(k);
        best = 0;
        ok   = 1'b0;
        for (int j = 1; j <= PAT_MAX; j++) begin
            ok = (j <= int'(len)) && (j <= m + 1) && (in == bit_at(p_seq, j - 1));
            for (int t = 0; t < PAT_MAX - 1; t++) begin
                if (ok && (t <= j - 2) && (bit_at(p_seq, m - j + 1 + t) != bit_at(p_seq, t)))
                    ok = 1'b0;
            end
            if (ok)
                best = j;
        end
        k_next = LEN_W'(best);
    end

    assign hit = en && !pat_load && (k_next == len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= DEFAULT_PAT;
            len     <= LEN_W'(DEFAULT_LEN);
            k       <= '0;
        end else if (pat_load) begin
            pattern <= pat_in;
            len     <= len_clamped;
            k       <= '0;
        end else if (en) begin
            k       <= k_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            match_cnt <= '0;
        else if (cnt_clr)
            match_cnt <= '0;
        else if (hit && match_cnt != '1)
            match_cnt <= match_cnt + CNT_W'(1);
    end

    assign out     = (k == len);
    assign state_k = k;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// tb/tb_seq_detect_moore_param.sv - scoreboard bench for seq_detect_moore_param against a string-matching model
module tb_seq_detect_moore_param;

    localparam int PAT_MAX = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               din = 1'b0;
    logic               overlap = 1'b1;
    logic               pat_load = 1'b0;
    logic [PAT_MAX-1:0] pat_in = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               cnt_clr = 1'b0;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic [LEN_W-1:0]   state_k;

    seq_detect_moore_param #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .in(din), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .pat_len(pat_len), .cnt_clr(cnt_clr),
        .out(out), .match_cnt(match_cnt), .state_k(state_k)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        bit o;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: the bits seen on the line, matched as strings against the pattern
    logic [PAT_MAX-1:0] mpat;
    int                 mlen;
    int                 mk;
    int                 mcnt;
    bit                 hist[$];

    function automatic bit pbit(input int t);
        logic [PAT_MAX-1:0] s;
        s = mpat >> (mlen - 1 - t);
        return s[0];
    endfunction

    function automatic int best_k();
        int n;
        bit same;
        n = hist.size();
        for (int j = mlen; j >= 1; j--) begin
            if (j <= n) begin
                same = 1'b1;
                for (int t = 0; t < j; t++)
                    if (hist[n - j + t] != pbit(t)) same = 1'b0;
                if (same) return j;
            end
        end
        return 0;
    endfunction

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > PAT_MAX) return PAT_MAX;
        return l;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.k = mk;
        e.o = (mk == mlen);
        e.c = mcnt;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mpat = PAT_MAX'(8'b0000_0101);
        mlen = 3;
        mk   = 0;
        mcnt = 0;
        hist.delete();
        push_exp();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit e, input bit b, input bit ov, input bit pl,
                        input logic [PAT_MAX-1:0] pi, input int plen, input bit cc);
        bit inc;
        en = e; din = b; overlap = ov; pat_load = pl;
        pat_in = pi; pat_len = LEN_W'(plen); cnt_clr = cc;
        @(posedge clk);
        inc = 1'b0;
        if (pl) begin
            mpat = pi;
            mlen = clamp_len(plen);
            mk   = 0;
            hist.delete();
        end else if (e) begin
            if (mk == mlen && !ov) hist.delete();
            hist.push_back(b);
            while (hist.size() > mlen) void'(hist.pop_front());
            mk = best_k();
            inc = (mk == mlen);
        end
        if (cc) mcnt = 0;
        else if (inc && mcnt < CNT_MAX) mcnt++;
        push_exp();
        @(negedge clk);
    endtask

    task automatic feed(input int n, input logic [15:0] bits, input bit ov);
        for (int i = n - 1; i >= 0; i--)
            step(1'b1, bits[i], ov, 1'b0, '0, 0, 1'b0);
    endtask

    task automatic load(input logic [PAT_MAX-1:0] pi, input int plen);
        step(1'b1, 1'b1, overlap, 1'b1, pi, plen, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 3;
                if (int'(state_k) != e.k) begin
                    errors++;
                    $display("FAIL state_k at %0t: got %0d expected %0d", $time, state_k, e.k);
                end
                if (out != e.o) begin
                    errors++;
                    $display("FAIL out at %0t: got %0b expected %0b", $time, out, e.o);
                end
                if (int'(match_cnt) != e.c) begin
                    errors++;
                    $display("FAIL match_cnt at %0t: got %0d expected %0d", $time, match_cnt, e.c);
                end
            end
        end
    end

    initial begin : driver
        bit ov;
        @(negedge clk);
        do_reset();

        feed(5, 16'b10101, 1'b1);
        do_reset();
        feed(5, 16'b10101, 1'b0);

        overlap = 1'b1;
        load(8'h0B, 4);
        feed(7, 16'b1011011, 1'b1);
        load(8'h0B, 0);
        feed(3, 16'b111, 1'b1);

        do_reset();
        feed(2, 16'b10, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, i[0], 1'b1, 1'b0, '0, 0, 1'b0);
        feed(1, 16'b1, 1'b1);

        load(8'h01, 1);
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 0, 1'b1);

        load(8'hF0, 8);
        feed(2, 16'b10, 1'b1);
        do_reset();
        feed(2, 16'b10, 1'b1);
        do_reset();
        feed(1, 16'b1, 1'b1);

        ov = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) ov = ~ov;
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else if ($urandom_range(0, 49) == 0)
                step(1'b0, 1'b0, ov, 1'b1, PAT_MAX'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 4)),
                     ($urandom_range(0, 59) == 0));
            else
                step(($urandom_range(0, 9) != 0), bit'($urandom_range(0, 1)), ov, 1'b0, '0, 0,
                     ($urandom_range(0, 59) == 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
